fetch_unit: RTL

Instruction-fetch stage of the five-stage pipeline: owns the PC register, issues requests to the instruction memory over a valid handshake, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the load-use hazard detection logic. It obeys that logic's PC-write and stall signals, keeping the PC and IF/ID frozen while a bubble is inserted downstream. It also handles branch-redirect flushes and variable-latency memory returns, including a redirect that arrives while a request is outstanding.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if : instruction-memory request/response handshake bundle
// Revision      : 1.0
// ============================================================================
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_valid_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_valid_i,
        output imem_data_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : IF stage - PC register, imem fetch handshake, IF/ID register
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        PCWrite_i,
    input  wire logic        Stall_i,
    input  wire logic        Flush_i,
    input  wire logic [31:0] branch_target_i,
    fetch_unit_if.master     imem,
    output logic      [31:0] IFID_pc_o,
    output logic      [31:0] IFID_instr_o,
    output logic             IFID_valid_o
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_buf_nxt;
    logic [31:0] w_redirect_nxt;
    logic [31:0] w_ifid_pc_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic        w_ifid_valid_nxt;

    logic        w_hold;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_hold   = Stall_i | ~PCWrite_i;
    assign w_target = {branch_target_i[31:2], 2'b00};
    assign w_pc_inc = r_pc + 32'd4;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect always wins over a hazard hold
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                if (Flush_i) begin
                    w_state_nxt = imem.imem_valid_i ? ST_REQ : ST_DRAIN;
                end else if (imem.imem_valid_i && w_hold) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Flush_i || !w_hold) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_valid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    // Request is suppressed while reset is held so memory never sees a stale fetch
    always_comb begin
        imem.imem_req_o  = rst_i && (r_state != ST_HOLD);
        imem.imem_addr_o = r_pc;
    end

    always_comb begin
        w_pc_nxt         = r_pc;
        w_buf_nxt        = r_buf_instr;
        w_redirect_nxt   = r_redirect_pc;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;
        case (r_state)
            ST_REQ: begin
                if (Flush_i) begin
                    if (imem.imem_valid_i) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redirect_nxt = w_target;
                    end
                end else if (imem.imem_valid_i) begin
                    if (!w_hold) begin
                        w_ifid_pc_nxt    = r_pc;
                        w_ifid_instr_nxt = imem.imem_data_i;
                        w_ifid_valid_nxt = 1'b1;
                        w_pc_nxt         = w_pc_inc;
                    end else begin
                        w_buf_nxt = imem.imem_data_i;
                    end
                end else if (!w_hold) begin
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (Flush_i) begin
                    w_pc_nxt = w_target;
                end else if (!w_hold) begin
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_instr_nxt = r_buf_instr;
                    w_ifid_valid_nxt = 1'b1;
                    w_pc_nxt         = w_pc_inc;
                end
            end
            ST_DRAIN: begin
                // The in-flight word belongs to the abandoned path and is dropped
                if (imem.imem_valid_i) begin
                    w_pc_nxt = Flush_i ? w_target : r_redirect_pc;
                end else if (Flush_i) begin
                    w_redirect_nxt = w_target;
                end
            end
            default: ;
        endcase
        if (Flush_i) begin
            w_ifid_pc_nxt    = w_target;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc          <= RESET_PC;
            r_buf_instr   <= 32'h0;
            r_redirect_pc <= 32'h0;
            r_ifid_pc     <= RESET_PC;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_buf_instr   <= w_buf_nxt;
            r_redirect_pc <= w_redirect_nxt;
            r_ifid_pc     <= w_ifid_pc_nxt;
            r_ifid_instr  <= w_ifid_instr_nxt;
            r_ifid_valid  <= w_ifid_valid_nxt;
        end
    end

    assign IFID_pc_o    = r_ifid_pc;
    assign IFID_instr_o = r_ifid_instr;
    assign IFID_valid_o = r_ifid_valid;

endmodule
`default_nettype wire
